// File: rtl/mac_neuron_if.sv
// Handshake and data bundle between an interlayer block and a mac_neuron.
// The master drives the activation set and start strobe; the neuron answers with its result.
interface mac_neuron_if;
    logic       start;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic [7:0] in4;
    logic [7:0] out;
    logic       ready;
    logic       busy;
    logic       overrun;

    modport master (
        output start, in1, in2, in3, in4,
        input  out, ready, busy, overrun
    );

    modport slave (
        input  start, in1, in2, in3, in4,
        output out, ready, busy, overrun
    );
endinterface

// File: rtl/mac_neuron.sv
// Serial 4-input multiply-accumulate neuron with arithmetic scaling and a saturating ReLU.
// One product is accumulated per cycle, and the clamped result is presented with a one-cycle ready pulse.
module mac_neuron #(
    parameter logic signed [7:0]  W0    = 8'sd0,
    parameter logic signed [7:0]  W1    = 8'sd0,
    parameter logic signed [7:0]  W2    = 8'sd0,
    parameter logic signed [7:0]  W3    = 8'sd0,
    parameter logic signed [15:0] BIAS  = 16'sd0,
    parameter int unsigned        SHIFT = 32'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    mac_neuron_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic signed [19:0] r_acc;
    logic [1:0]         r_idx;
    logic [7:0]         r_in1;
    logic [7:0]         r_in2;
    logic [7:0]         r_in3;
    logic [7:0]         r_in4;
    logic [7:0]         r_out;
    logic               r_ready;
    logic               r_busy;
    logic               r_overrun;

    logic [7:0]         w_sel_in;
    logic signed [7:0]  w_sel_w;
    logic signed [16:0] w_ext_in;
    logic signed [16:0] w_ext_w;
    logic signed [16:0] w_prod;
    logic signed [19:0] w_shifted;
    logic               w_accept;

    // Clamp the scaled accumulator into the unsigned 8-bit activation range.
    function automatic logic [7:0] relu_sat(input logic signed [19:0] v);
        logic [7:0] res;
        if (v < 20'sd0) begin
            res = 8'd0;
        end else if (v > 20'sd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    // Select the captured activation and its weight for the current MAC step.
    always_comb begin
        w_sel_in = 8'd0;
        w_sel_w  = 8'sd0;
        case (r_idx)
            2'd0:    begin w_sel_in = r_in1; w_sel_w = W0; end
            2'd1:    begin w_sel_in = r_in2; w_sel_w = W1; end
            2'd2:    begin w_sel_in = r_in3; w_sel_w = W2; end
            2'd3:    begin w_sel_in = r_in4; w_sel_w = W3; end
            default: begin w_sel_in = 8'd0;  w_sel_w = 8'sd0; end
        endcase
    end

    // Activation is unsigned, weight signed; 17 bits hold any product exactly.
    assign w_ext_in  = {9'd0, w_sel_in};
    assign w_ext_w   = {{9{w_sel_w[7]}}, w_sel_w};
    assign w_prod    = w_ext_in * w_ext_w;
    assign w_shifted = r_acc >>> SHIFT;
    assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Neuron state machine: capture, four MAC steps, then publish the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= 20'sd0;
            r_idx     <= 2'd0;
            r_in1     <= 8'd0;
            r_in2     <= 8'd0;
            r_in3     <= 8'd0;
            r_in4     <= 8'd0;
            r_out     <= 8'd0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                end
                S_MAC: begin
                    r_acc <= r_acc + {{3{w_prod[16]}}, w_prod};
                    r_idx <= r_idx + 2'd1;
                    if (bus.start) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_idx == 2'd3) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_out   <= relu_sat(w_shifted);
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A new set accepted here overrides the IDLE fall-through of DONE.
            if (w_accept) begin
                r_in1   <= bus.in1;
                r_in2   <= bus.in2;
                r_in3   <= bus.in3;
                r_in4   <= bus.in4;
                r_acc   <= {{4{BIAS[15]}}, BIAS};
                r_idx   <= 2'd0;
                r_state <= S_MAC;
                r_busy  <= 1'b1;
            end
        end
    end

    assign bus.out     = r_out;
    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.overrun = r_overrun;

endmodule

// File: doc/mac_neuron.md
Name: mac_neuron

Overview:
- Serial multiply-accumulate neuron. It sits directly downstream of the interlayer block and consumes that block's four held 8-bit activations plus its ready_out strobe.
- It computes relu_sat((bias + sum of Wi*ini) >>> SHIFT) over 4 MAC cycles and emits one 8-bit activation with a one-cycle ready pulse. That output/pulse pair drives the next interlayer's inN/readyN pair.
- It is the per-neuron compute stage of each network layer.

Parameters:
- W0, 0, signed 8-bit weight applied to in1
- W1, 0, signed 8-bit weight applied to in2
- W2, 0, signed 8-bit weight applied to in3
- W3, 0, signed 8-bit weight applied to in4
- BIAS, 0, signed 16-bit bias preloaded into the accumulator
- SHIFT, 0, arithmetic right shift (0..11) applied before activation

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low (one clock; reset sampled only on rising clk edge)
- start  input  1  level; sampled high while accepting = new input set (wired from interlayer ready_out)
- in1  input  8  unsigned activation 1
- in2  input  8  unsigned activation 2
- in3  input  8  unsigned activation 3
- in4  input  8  unsigned activation 4
- out  output  8  registered unsigned result, held until next result
- ready  output  1  one-cycle pulse: out valid
- busy  output  1  high in MAC and DONE states
- overrun  output  1  sticky: start seen while in MAC state; cleared only by reset

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, acc=0, idx=0, out=8'h00, ready=0, busy=0, overrun=0, captured inputs=0. Reset mid-computation aborts the computation; no ready pulse follows.
- States: IDLE, MAC, DONE. busy=1 iff state is MAC or DONE.
- Start acceptance is in IDLE or DONE with start=1 at edge E0:
  - in1..in4 are captured into internal registers; later input changes are ignored.
  - acc <= sign-extended BIAS; idx <= 0; state <= MAC.
- MAC state, edges E1..E4: acc <= acc + (zero-extended in[idx] * sign-extended W[idx]) as a signed 17-bit product; idx increments.
  - The edge with idx=3 (E4) goes to DONE.
- DONE state, edge E5:
  - r = acc >>> SHIFT (arithmetic).
  - out <= 0 if r<0; 255 if r>255; else r[7:0].
  - ready <= 1 for exactly the cycle following E5.
  - Next state is MAC if start=1 (new set accepted in the same edge, as in the IDLE rule); else IDLE.
- Latency: start edge E0 to ready high after E5 = 5 cycles. Peak throughput is one result per 5 cycles back-to-back.
- ready is 0 in every other cycle. out changes only at DONE edges and reset.
- Accumulator width is signed 20 bits. The worst case |4*255*128 + 32768| < 2^19, so no overflow is possible and no wrap is permitted.
- start=1 while in MAC is ignored (computation continues unchanged) and sets overrun=1.
- start held high continuously restarts at each DONE edge. The inputs captured are those present at that edge.
- rst_n low has priority over start in the same cycle.

Test Plan:
- W0..W3=1,2,-1,3, BIAS=0, SHIFT=0; start pulse with in=10,20,30,40 -> ready exactly 5 cycles later, out=140; busy high 5 cycles.
- Same weights, in=100,100,0,0 -> sum 300 -> out=255; in=0,0,50,0 -> sum -50 -> out=0 (ReLU clamp).
- BIAS=-8, SHIFT=2, in=10,20,30,40 -> (140-8)>>>2=33 -> out=33; inputs changed during MAC must not alter the result.
- start held high for 12 cycles with in=10,20,30,40 -> two ready pulses 5 cycles apart, both out=140. A start pulse injected at cycle 2 of MAC -> overrun=1, result still 140, overrun stays 1 until reset.
- rst_n low during cycle 3 of MAC -> out=0, ready never pulses, busy=0. Next start with in=1,1,1,1 (W=1,2,-1,3) -> out=5.
- Simultaneous rst_n=0 and start=1 -> remains IDLE, busy=0, no result.
